// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronises and filters the device clock, deframes
// start/8 data/odd parity/stop frames and queues valid bytes in a FWFT FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          read_enable,
  input  logic                          clear_err,
  output logic [7:0]                    data,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   filt_q, filt_d;
  logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic clk_s, data_s, fall;
  logic push, set_perr, set_ferr;
  logic [AW:0] level_w;
  logic full, pop, wr_en;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = dat_sync_q[SYNC_STAGES-1];

  // Filtered level flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall = filt_q & ~filt_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = '0;
    push      = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (state_q == IDLE) begin
      if (fall) begin
        if (!data_s) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          set_ferr = 1'b1;
        end
      end
    end else if (fall) begin
      case (state_q)
        DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        default: begin
          state_d  = IDLE;
          push     = data_s & (^{shift_q, par_q});
          set_ferr = ~data_s;
          set_perr = ~(^{shift_q, par_q});
        end
      endcase
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      set_ferr  = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // A full FIFO still accepts a push when a pop happens in the same cycle
  always_comb begin
    level_w  = wr_ptr_q - rd_ptr_q;
    full     = (level_w == (AW+1)'(FIFO_DEPTH));
    pop      = read_enable & (level_w != '0);
    wr_en    = push & (~full | pop);
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    perr_d   = (perr_q & ~clear_err) | set_perr;
    ferr_d   = (ferr_q & ~clear_err) | set_ferr;
    ovf_d    = (ovf_q & ~clear_err) | (push & full & ~pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign data       = mem_q[rd_ptr_q[AW-1:0]];
  assign ready      = (level_w != '0);
  assign level      = level_w;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames, hand-computed results.
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_enable = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data;
  logic       ready;
  logic [4:0] level;
  logic       parity_err, frame_err, overflow;

  int n_vec = 0;
  int n_err = 0;

  ps2_rx_fifo #(
    .FIFO_DEPTH(16),
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .read_enable(read_enable), .clear_err(clear_err),
    .data(data), .ready(ready), .level(level),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One PS/2 bit; with re set, read_enable is high in the cycle whose
  // closing edge commits the filtered falling edge (6 cycles after the drop).
  task automatic ps2_bit(input logic b, input bit re);
    ps2_data = b;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    if (re) begin
      repeat (5) @(negedge clk);
      read_enable = 1'b1;
      @(negedge clk);
      read_enable = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input bit re);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(stop, re);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 1'b0);
  endtask

  task automatic pulse_read();
    read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_level", level, 0);
    check("rst_flags", {parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // read on empty has no effect
    pulse_read();
    check("empty_read_level", level, 0);

    // 0x1C has three ones, so correct odd parity bit is 0
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("v1c_ready", ready, 1);
    check("v1c_data", data, 8'h1C);
    check("v1c_level", level, 1);
    check("v1c_flags", {parity_err, frame_err, overflow}, 0);
    pulse_read();
    check("v1c_pop_ready", ready, 0);
    check("v1c_pop_level", level, 0);

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("perr_flag", parity_err, 1);
    check("perr_ferr", frame_err, 0);
    check("perr_ready", ready, 0);
    pulse_clear();
    check("perr_clear", parity_err, 0);

    send_frame(8'hA5, ~^8'hA5, 1'b0, 1'b0);
    check("stop0_flags", {parity_err, frame_err}, 2'b01);
    check("stop0_ready", ready, 0);
    pulse_clear();

    for (int i = 0; i < 17; i++) send_ok(8'(i));
    check("ovf_level", level, 16);
    check("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", data, 16'(i));
      pulse_read();
    end
    check("ovf_empty", ready, 0);
    pulse_clear();
    check("ovf_clear", overflow, 0);

    for (int i = 0; i < 16; i++) send_ok(8'h20 + 8'(i));
    check("simul_full", level, 16);
    send_frame(8'h55, ~^8'h55, 1'b1, 1'b1);
    check("simul_level", level, 16);
    check("simul_ovf", overflow, 0);
    for (int i = 1; i < 16; i++) begin
      check("simul_drain", data, 16'(8'h20 + 8'(i)));
      pulse_read();
    end
    check("simul_last", data, 8'h55);
    pulse_read();
    check("simul_empty", ready, 0);

    ps2_bit(1'b0, 1'b0);
    b = 8'h0A;
    for (int i = 0; i < 4; i++) ps2_bit(b[i], 1'b0);
    repeat (5100) @(negedge clk);
    check("to_ferr", frame_err, 1);
    check("to_ready", ready, 0);
    pulse_clear();
    send_ok(8'hF0);
    check("to_next_data", data, 8'hF0);
    check("to_next_level", level, 1);
    check("to_next_flags", {parity_err, frame_err, overflow}, 0);
    pulse_read();

    send_ok(8'h33);
    send_frame(8'h33, ~^8'h33, 1'b0, 1'b0);
    check("pre_rst_state", {ready, frame_err}, 2'b11);
    b = 8'hAA;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(b[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", ready, 0);
    check("midrst_level", level, 0);
    check("midrst_flags", {parity_err, frame_err, overflow}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_ok(8'hE0);
    check("post_rst_data", data, 8'hE0);
    check("post_rst_level", level, 1);
    check("post_rst_flags", {parity_err, frame_err, overflow}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on ps2_clk and ps2_data; minimum 2.
REQ-003 SHALL have parameter FILTER_LEN, default 4: consecutive equal synchronised ps2_clk samples needed to change the filtered level.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 5000: clk cycles without a filtered falling edge before a partial frame is aborted.
REQ-005 SHALL have port clk, input, 1: sole clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port ps2_clk, input, 1: asynchronous PS/2 device clock.
REQ-008 SHALL have port ps2_data, input, 1: asynchronous PS/2 device data.
REQ-009 SHALL have port read_enable, input, 1: pops the FIFO head when ready is 1.
REQ-010 SHALL have port clear_err, input, 1: clears all sticky error flags.
REQ-011 SHALL have port data, output, 8: FIFO head byte, first-word fall-through.
REQ-012 SHALL have port ready, output, 1: FIFO not empty.
REQ-013 SHALL have port level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port parity_err, output, 1: sticky; a frame failed the odd-parity check.
REQ-015 SHALL have port frame_err, output, 1: sticky; bad start bit, bad stop bit or timeout.
REQ-016 SHALL have port overflow, output, 1: sticky; a valid byte was dropped because the FIFO was full.

Function
REQ-017 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each; no unsynchronised input SHALL reach logic.
REQ-018 SHALL derive the filtered clock level from the synchronised ps2_clk; it changes only after FILTER_LEN consecutive equal samples, and a 1->0 change of the filtered level is one falling-edge event.
REQ-019 SHALL, on each falling-edge event, sample the synchronised ps2_data in that same cycle.
REQ-020 SHALL implement receiver states IDLE, DATA, PARITY and STOP.
REQ-021 SHALL, in IDLE on an edge: if the sampled bit is 0, go to DATA with bit count 0; if it is 1, set frame_err and stay in IDLE.
REQ-022 SHALL, in DATA on each edge, shift the sampled bit in LSB first; after the 8th bit, go to PARITY.
REQ-023 SHALL, in PARITY on an edge, store the parity bit and go to STOP.
REQ-024 SHALL, in STOP on an edge, return to IDLE and classify the frame:
- valid: stop bit 1 and the 8 data bits plus parity have odd total ones;
- stop bit 0: set frame_err and discard the byte;
- parity wrong with stop bit 1: set parity_err and discard the byte;
- both wrong: set both flags and discard the byte.
REQ-025 SHALL, for a valid frame whose STOP edge is in cycle N, write the byte into the FIFO at the end of cycle N if the FIFO is not full, so ready and data reflect it in cycle N+1.
REQ-026 SHALL count cycles since the last edge while in DATA, PARITY or STOP; on reaching TIMEOUT_CYCLES, abort to IDLE, discard the partial byte and set frame_err.
REQ-027 SHALL pop the head at the clk edge when read_enable and ready are both 1; read_enable while ready is 0 SHALL have no effect.
REQ-028 SHALL hold data at the head entry whenever ready is 1; data is don't-care while ready is 0.
REQ-029 SHALL wrap read and write pointers modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty; all FIFO_DEPTH entries are usable.
REQ-030 SHALL, when a push and a pop occur in the same cycle, perform both: level is unchanged, and a full FIFO accepts the new byte with no overflow.
REQ-031 SHALL, on a push to a full FIFO with no simultaneous pop, drop the byte, set overflow and leave FIFO contents and level unchanged.
REQ-032 SHALL clear all sticky flags on clear_err; if a new error occurs in the same cycle, the set SHALL win.
REQ-033 SHALL keep level equal to pushes minus pops, within the range 0..FIFO_DEPTH.

Reset
REQ-034 SHALL, while rst is 1, asynchronously force:
- receiver state to IDLE, with bit count, shift register and timeout counter at 0;
- FIFO pointers to 0, level 0 and ready 0;
- parity_err, frame_err and overflow to 0;
- synchronisers and the filtered level to 1 (bus idle).
REQ-035 SHALL discard any partial frame when rst asserts mid-frame; after release, the next byte SHALL need a fresh start bit.
REQ-036 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-037 SHALL cover: frame 0x1C with parity 0 and stop 1 -> ready=1, data=0x1C, level=1; one read_enable pulse -> ready=0, level=0.
REQ-038 SHALL cover: frame 0x1C with parity 1 -> parity_err=1, ready stays 0; clear_err pulse -> parity_err=0.
REQ-039 SHALL cover: 17 valid bytes 0x00..0x10 with no reads (FIFO_DEPTH=16) -> level=16, overflow=1; draining returns 0x00..0x0F in order.
REQ-040 SHALL cover: full FIFO, read_enable held in the STOP-edge cycle of byte 0x55 -> level stays 16, overflow=0, 0x55 is the last byte out.
REQ-041 SHALL cover: start bit plus 4 data bits, then ps2_clk idle for 5000 cycles -> frame_err=1, state IDLE; a following valid 0xF0 is received correctly.
REQ-042 SHALL cover: rst pulse after the 6th edge of a frame -> all outputs at reset values; a following valid 0xE0 is received as 0xE0.
